fma16_rr_arbiter: RTL and testbench

Shares one combinational fma16 datapath between NREQ requesters, each using a valid/ready handshake. Grants are round-robin, and only one operation is in flight at a time. Operands are registered before they drive the fma16 ports; result and flags are registered before they are returned on a shared response bus with a per-requester valid. The block sits between the requesting units and the single fma16 instance.

---
 rtl/fma16_rr_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_fma16_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_rr_arbiter.sv
// fma16_rr_arbiter
// Round-robin front end that shares a single combinational fma16 datapath
// between NREQ valid/ready requesters. One operation is in flight at a time.
// Operands are registered before they reach the fma16 ports. Result and flags
// are registered before they go out on the shared response bus, which carries
// a one-hot valid for the requester that owns the result.
//
// state | meaning
// IDLE  | nothing in flight; any valid request is accepted
// EXEC  | operand registers drive fma16; result is captured at the next edge
// RESP  | result held on the response bus until the owner accepts it

module fma16_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_z,
    input  logic [6*NREQ-1:0]    req_op,

    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [15:0]          resp_result,
    output logic [3:0]           resp_flags,

    output logic                 busy,

    output logic [15:0]          fma_x,
    output logic [15:0]          fma_y,
    output logic [15:0]          fma_z,
    output logic                 fma_mul,
    output logic                 fma_add,
    output logic                 fma_negp,
    output logic                 fma_negz,
    output logic [1:0]           fma_roundmode,
    input  logic [15:0]          fma_result,
    input  logic [3:0]           fma_flags
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [GW-1:0]     last_grant_q;
    logic [GW-1:0]     gnt_q;
    logic [15:0]       x_q;
    logic [15:0]       y_q;
    logic [15:0]       z_q;
    logic [5:0]        op_q;
    logic [NREQ-1:0]   resp_valid_q;
    logic [15:0]       resp_result_q;
    logic [3:0]        resp_flags_q;

    logic [GW-1:0]     grant_sel;
    logic              any_valid;
    logic              accept_slot;
    logic              resp_hs;
    logic              req_hs;
    logic [NREQ-1:0]   gnt_onehot;
    logic [15:0]       x_d;
    logic [15:0]       y_d;
    logic [15:0]       z_d;
    logic [5:0]        op_d;

    assign any_valid = |req_valid;

    // Round-robin pick: first valid requester after the last grant, wrapping.
    always_comb begin
        logic [GW:0] cand;
        logic        found;
        cand      = '0;
        found     = 1'b0;
        grant_sel = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant_q} + (GW+1)'(k);
            if (cand >= (GW+1)'(NREQ)) begin
                cand = cand - (GW+1)'(NREQ);
            end
            if (!found && req_valid[cand[GW-1:0]]) begin
                found     = 1'b1;
                grant_sel = cand[GW-1:0];
            end
        end
    end

    // Operand mux: the granted requester's fields become the next operand values.
    always_comb begin
        x_d  = '0;
        y_d  = '0;
        z_d  = '0;
        op_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_sel == GW'(i)) begin
                x_d  = req_x[16*i +: 16];
                y_d  = req_y[16*i +: 16];
                z_d  = req_z[16*i +: 16];
                op_d = req_op[6*i +: 6];
            end
        end
    end

    // A new request can only be taken when idle, or when the pending result
    // is being accepted by its owner in this same cycle.
    assign resp_hs     = (state_q == RESP) & resp_valid_q[gnt_q] & resp_ready[gnt_q];
    assign accept_slot = (state_q == IDLE) | resp_hs;
    assign req_hs      = accept_slot & any_valid;

    // Per-requester ready: at most one bit, the current round-robin pick.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept_slot & any_valid & (grant_sel == GW'(i));
        end
    end

    // One-hot decode of the owning requester for the response valid.
    always_comb begin
        gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_onehot[i] = (gnt_q == GW'(i));
        end
    end

    // Sequencer: request capture, single-cycle execute, response hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GW'(NREQ-1);
            gnt_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            op_q          <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_hs) begin
                        x_q          <= x_d;
                        y_q          <= y_d;
                        z_q          <= z_d;
                        op_q         <= op_d;
                        gnt_q        <= grant_sel;
                        last_grant_q <= grant_sel;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result_q <= fma_result;
                    resp_flags_q  <= fma_flags;
                    resp_valid_q  <= gnt_onehot;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (resp_hs) begin
                        resp_valid_q <= '0;
                        if (req_hs) begin
                            x_q          <= x_d;
                            y_q          <= y_d;
                            z_q          <= z_d;
                            op_q         <= op_d;
                            gnt_q        <= grant_sel;
                            last_grant_q <= grant_sel;
                            state_q      <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = (state_q != IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_result   = resp_result_q;
    assign resp_flags    = resp_flags_q;

    // The fma16 sees only registered operands, so they hold while idle.
    assign fma_x         = x_q;
    assign fma_y         = y_q;
    assign fma_z         = z_q;
    assign fma_roundmode = op_q[5:4];
    assign fma_mul       = op_q[3];
    assign fma_add       = op_q[2];
    assign fma_negp      = op_q[1];
    assign fma_negz      = op_q[0];

endmodule

// File: tb/tb_fma16_rr_arbiter.sv
// Bench for fma16_rr_arbiter: a stand-in fma16, a transaction-level model of
// the arbiter, a per-cycle compare process and directed scenarios.

module tb_fma16_rr_arbiter;

    localparam int NREQ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_x;
    logic [16*NREQ-1:0]   req_y;
    logic [16*NREQ-1:0]   req_z;
    logic [6*NREQ-1:0]    req_op;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [15:0]          resp_result;
    logic [3:0]           resp_flags;
    logic                 busy;
    logic [15:0]          fma_x, fma_y, fma_z;
    logic                 fma_mul, fma_add, fma_negp, fma_negz;
    logic [1:0]           fma_roundmode;
    logic [15:0]          fma_result;
    logic [3:0]           fma_flags;

    fma16_rr_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .busy(busy),
        .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
        .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
        .fma_roundmode(fma_roundmode),
        .fma_result(fma_result), .fma_flags(fma_flags)
    );

    // Stand-in for fma16: exact results for the two directed arithmetic
    // vectors, an operand-sensitive scramble for everything else.
    function automatic logic [19:0] fma_stub(input logic [15:0] x, input logic [15:0] y,
                                             input logic [15:0] z, input logic [5:0] op);
        if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && op == 6'b001100)
            return {16'h4200, 4'b0000};
        if (x == 16'h3C00 && y == 16'h3C00 && z == 16'h3C00 && op == 6'b001101)
            return {16'h0000, 4'b0000};
        return {x ^ {y[14:0], 1'b0} ^ {1'b0, z[15:1]} ^ {10'd0, op},
                x[3:0] ^ z[3:0] ^ op[3:0]};
    endfunction

    assign {fma_result, fma_flags} =
        fma_stub(fma_x, fma_y, fma_z, {fma_roundmode, fma_mul, fma_add, fma_negp, fma_negz});

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // phase 0 = nothing outstanding, 1 = operation executing, 2 = result waiting
    int          m_phase = 0;
    int          m_last  = NREQ-1;
    int          m_owner = 0;
    logic [15:0] m_x = '0, m_y = '0, m_z = '0, m_res = '0;
    logic [5:0]  m_op = '0;
    logic [3:0]  m_flg = '0;

    function automatic logic [NREQ-1:0] onehot(input int p);
        logic [NREQ-1:0] r;
        r = '0;
        if (p >= 0 && p < NREQ) r[p] = 1'b1;
        return r;
    endfunction

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic model_accepts();
        return (m_phase == 0) || (m_phase == 2 && resp_ready[m_owner]);
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int p;
        p = pick();
        if (p >= 0 && model_accepts()) return onehot(p);
        return '0;
    endfunction

    always @(posedge clk or posedge reset) begin : model_upd
        int p;
        logic acc;
        if (reset) begin
            m_phase = 0; m_last = NREQ-1; m_owner = 0;
            m_x = '0; m_y = '0; m_z = '0; m_op = '0; m_res = '0; m_flg = '0;
        end else if (m_phase == 1) begin
            {m_res, m_flg} = fma_stub(m_x, m_y, m_z, m_op);
            m_phase = 2;
        end else begin
            acc = model_accepts();
            p   = pick();
            if (acc && p >= 0) begin
                m_x = req_x[16*p +: 16];
                m_y = req_y[16*p +: 16];
                m_z = req_z[16*p +: 16];
                m_op = req_op[6*p +: 6];
                m_owner = p;
                m_last  = p;
                m_phase = 1;
            end else if (m_phase == 2 && acc) begin
                m_phase = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_req_ready", 32'(req_ready), 32'(exp_ready()));
        chk("cyc_resp_valid", 32'(resp_valid), 32'((m_phase == 2) ? onehot(m_owner) : '0));
        chk("cyc_busy", 32'(busy), 32'(m_phase != 0));
        chk("cyc_resp_result", 32'(resp_result), 32'(m_res));
        chk("cyc_resp_flags", 32'(resp_flags), 32'(m_flg));
        chk("cyc_fma_x", 32'(fma_x), 32'(m_x));
        chk("cyc_fma_y", 32'(fma_y), 32'(m_y));
        chk("cyc_fma_z", 32'(fma_z), 32'(m_z));
        chk("cyc_fma_ctrl", 32'({fma_roundmode, fma_mul, fma_add, fma_negp, fma_negz}), 32'(m_op));
    end

    // Request handshake log (index and cycle) for the round-robin scenario.
    int cyc = 0;
    int g_idx[$];
    int g_cyc[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    g_idx.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input logic [5:0] op);
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
        req_z[16*i +: 16] = z;
        req_op[6*i +: 6]  = op;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [19:0] r2, r3;
        int exp_rr[6];
        req_valid = '0; resp_ready = '0;
        req_x = '0; req_y = '0; req_z = '0; req_op = '0;
        #2 reset = 1'b1;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_result", 32'(resp_result), 32'd0);
        chk("rst_fma_x", 32'(fma_x), 32'd0);
        reset = 1'b0;

        // single request from requester 1
        tick();
        set_req(1, 16'h3C00, 16'h4000, 16'h3C00, 6'b001100);
        req_valid = 4'b0010;
        #1 chk("single_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        chk("single_exec_busy", 32'(busy), 32'd1);
        chk("single_exec_resp_valid", 32'(resp_valid), 32'd0);
        chk("single_fma_x", 32'(fma_x), 32'h3C00);
        chk("single_fma_y", 32'(fma_y), 32'h4000);
        chk("single_fma_ctrl", 32'({fma_roundmode, fma_mul, fma_add, fma_negp, fma_negz}), 32'h0C);
        tick();
        chk("single_resp_valid", 32'(resp_valid), 32'h2);
        chk("single_result", 32'(resp_result), 32'h4200);
        chk("single_flags", 32'(resp_flags), 32'h0);
        chk("single_resp_busy", 32'(busy), 32'd1);
        tick();
        chk("single_hold_valid", 32'(resp_valid), 32'h2);
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        #1;
        chk("single_done_valid", 32'(resp_valid), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);
        chk("idle_fma_x_hold", 32'(fma_x), 32'h3C00);

        // negated addend from requester 0, with a wrong-owner ready first
        set_req(0, 16'h3C00, 16'h3C00, 16'h3C00, 6'b001101);
        req_valid = 4'b0001;
        #1 chk("negz_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        chk("negz_result", 32'(resp_result), 32'h0000);
        chk("negz_resp_valid", 32'(resp_valid), 32'h1);
        resp_ready = 4'b0010;
        tick();
        chk("wrong_owner_valid", 32'(resp_valid), 32'h1);
        chk("wrong_owner_busy", 32'(busy), 32'd1);
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        #1 chk("negz_done_busy", 32'(busy), 32'd0);

        // reset asserted between edges while an operation is executing
        set_req(2, 16'h1234, 16'h5678, 16'h9ABC, 6'b110110);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        chk("mid_exec_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("async_rst_fma_x", 32'(fma_x), 32'd0);
        chk("async_rst_roundmode", 32'(fma_roundmode), 32'd0);
        tick();
        reset = 1'b0;

        // round robin with everyone valid and all results accepted at once
        for (int i = 0; i < NREQ; i++)
            set_req(i, 16'h1000 + 16'(i), 16'h2000 + 16'(17*i), 16'h0300 + 16'(5*i), 6'(9*i + 1));
        resp_ready = 4'hF;
        g_idx.delete();
        g_cyc.delete();
        req_valid = 4'hF;
        repeat (12) tick();
        req_valid = '0;
        repeat (3) tick();
        resp_ready = '0;
        exp_rr = '{0, 1, 2, 3, 0, 1};
        chk("rr_handshake_count", 32'(g_idx.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_grant_%0d", i), 32'((i < g_idx.size()) ? g_idx[i] : -1), 32'(exp_rr[i]));
            if (i > 0)
                chk($sformatf("rr_spacing_%0d", i),
                    32'((i < g_cyc.size()) ? g_cyc[i] - g_cyc[i-1] : -1), 32'd2);
        end

        // backpressure on requester 2 with requester 3 waiting
        set_req(2, 16'hA5A5, 16'h0F0F, 16'h1111, 6'b010100);
        set_req(3, 16'h7E00, 16'h00FF, 16'h4444, 6'b101000);
        r2 = fma_stub(16'hA5A5, 16'h0F0F, 16'h1111, 6'b010100);
        r3 = fma_stub(16'h7E00, 16'h00FF, 16'h4444, 6'b101000);
        req_valid = 4'b0100;
        #1 chk("bp_req2_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1000;
        resp_ready = 4'b1011;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_req_ready_low", 32'(req_ready), 32'd0);
            chk("bp_resp_valid", 32'(resp_valid), 32'h4);
            chk("bp_result", 32'(resp_result), 32'(r2[19:4]));
            chk("bp_flags", 32'(resp_flags), 32'(r2[3:0]));
            tick();
        end
        resp_ready = 4'b0100;
        #1 chk("bp_req3_ready", 32'(req_ready), 32'h8);
        tick();
        resp_ready = '0;
        req_valid = '0;
        #1;
        chk("bp_req3_exec_valid", 32'(resp_valid), 32'd0);
        chk("bp_req3_exec_busy", 32'(busy), 32'd1);
        chk("bp_req3_fma_x", 32'(fma_x), 32'h7E00);
        tick();
        chk("bp_req3_resp_valid", 32'(resp_valid), 32'h8);
        chk("bp_req3_result", 32'(resp_result), 32'(r3[19:4]));
        resp_ready = 4'b1000;
        tick();
        resp_ready = '0;
        #1 chk("bp_final_busy", 32'(busy), 32'd0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
